// File: rtl/seq_pkg.sv
// Shared definitions for the sequence-detector chain: serializer state type,
// counter width helper and the common reset level.
package seq_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } ser_state_t;

   // Reset level shared by every block in the detector chain.
   localparam logic RST_ACTIVE = 1'b1;

   // Width of a counter that indexes bits 0..width-1 of a word.
   function automatic int ser_cnt_w(input int width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/seq_serializer_if.sv
// Word handshake plus serial output bundle of the serializer.
interface seq_serializer_if #(
   parameter int WIDTH = 8
);

   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic             ser_en;
   logic             ser_bit;
   logic             ser_valid;
   logic             word_done;

   // Word producer and serial consumer side.
   modport master (
      output in_data, in_valid, ser_en,
      input  in_ready, ser_bit, ser_valid, word_done
   );

   // Serializer side.
   modport slave (
      input  in_data, in_valid, ser_en,
      output in_ready, ser_bit, ser_valid, word_done
   );

endinterface

// File: rtl/ser_shift_reg.sv
// Loadable WIDTH-bit shift register. Load wins over shift; with neither
// asserted the contents hold. MSB_FIRST selects shift-left versus shift-right.
module ser_shift_reg
   import seq_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] load_data,
   output logic [WIDTH-1:0] q
);

   // Load a new word, advance one position, or hold.
   // NOTE: sequential state uses non-blocking assignments and an async reset
   // in the sensitivity list, so every register clears without a clock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst == RST_ACTIVE) begin
         q <= '0;
      end else if (load) begin
         q <= load_data;
      end else if (shift) begin
         q <= MSB_FIRST ? {q[WIDTH-2:0], 1'b0} : {1'b0, q[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/seq_serializer.sv
// Parallel-to-serial front end. Accepts words over valid/ready and presents
// them one bit per enabled clock on ser_bit. A new word may be accepted while
// the last bit of the current one is shown, giving a gap-free stream.
module seq_serializer
   import seq_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic           clk,
   input  logic           rst,
   seq_serializer_if.slave bus
);

   localparam int                   CNT_W    = ser_cnt_w(WIDTH);
   localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [0:0]           ST_IDLE  = IDLE;
   localparam logic [0:0]           ST_SHIFT = SHIFT;

   logic [0:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] sr_q;
   logic             last_bit;
   logic             accept;
   logic             do_shift;

   assign last_bit     = (state == ST_SHIFT) && (cnt == CNT_LAST);
   assign bus.in_ready = (state == ST_IDLE) || (last_bit && bus.ser_en);
   assign accept       = bus.in_valid && bus.in_ready;
   assign do_shift     = (state == ST_SHIFT) && bus.ser_en && !last_bit;

   // FSM and bit counter: count through a word, reload back-to-back or drop to idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst == RST_ACTIVE) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  state <= ST_SHIFT;
                  cnt   <= '0;
               end
            end
            default: begin
               if (bus.ser_en) begin
                  if (!last_bit) begin
                     cnt <= cnt + 1'b1;
                  end else if (accept) begin
                     cnt <= '0;
                  end else begin
                     state <= ST_IDLE;
                     cnt   <= '0;
                  end
               end
            end
         endcase
      end
   end

   ser_shift_reg #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_shift_reg (
      .clk       (clk),
      .rst       (rst),
      .load      (accept),
      .shift     (do_shift),
      .load_data (bus.in_data),
      .q         (sr_q)
   );

   assign bus.ser_bit   = (state == ST_SHIFT) ? (MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0]) : 1'b0;
   assign bus.ser_valid = (state == ST_SHIFT);
   assign bus.word_done = last_bit;

endmodule

// File: tb/tb_seq_serializer.sv
// Self-checking bench for seq_serializer: queue-based reference model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_seq_serializer;

   localparam int W = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   seq_serializer_if #(.WIDTH(W)) bus ();
   seq_serializer_if #(.WIDTH(W)) bus2 ();

   seq_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   seq_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
      .clk (clk),
      .rst (rst),
      .bus (bus2.slave)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: queue of bits still to be presented for the MSB-first DUT.
   bit mq[$];
   int model_accepts = 0;

   function automatic bit model_ready();
      return (mq.size() == 0) || (mq.size() == 1 && bus.ser_en);
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mq.delete();
      end else begin
         bit rdy;
         rdy = model_ready();
         if (mq.size() != 0 && bus.ser_en) void'(mq.pop_front());
         if (bus.in_valid && rdy) begin
            model_accepts++;
            for (int i = W - 1; i >= 0; i--) mq.push_back(bus.in_data[i]);
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      bit e_valid;
      bit e_bit;
      bit e_done;
      e_valid = (mq.size() != 0);
      e_bit   = e_valid ? mq[0] : 1'b0;
      e_done  = (mq.size() == 1);
      check("ser_valid", bus.ser_valid, e_valid);
      check("ser_bit",   bus.ser_bit,   e_bit);
      check("word_done", bus.word_done, e_done);
      check("in_ready",  bus.in_ready,  model_ready());
   end

   // Capture of presented bits for the literal checks, plus a 101 detector
   // that samples only when ser_en && ser_valid.
   bit cap_bit[$];
   bit cap_done[$];
   bit cap_gate[$];
   int cap_cyc[$];
   bit cap2[$];
   int det_pos[$];
   bit [2:0] hist;
   int gcount;
   int cyc = 0;

   always @(negedge clk) begin
      cyc++;
      if (!rst && bus.ser_valid) begin
         cap_bit.push_back(bus.ser_bit);
         cap_done.push_back(bus.word_done);
         cap_cyc.push_back(cyc);
         if (bus.ser_en) begin
            cap_gate.push_back(bus.ser_bit);
            gcount++;
            hist = {hist[1:0], bus.ser_bit};
            if (gcount >= 3 && hist == 3'b101) det_pos.push_back(gcount);
         end
      end
      if (!rst && bus2.ser_valid) cap2.push_back(bus2.ser_bit);
   end

   function automatic logic [31:0] pack_q(input bit q[$]);
      logic [31:0] v;
      v = '0;
      foreach (q[i]) v = {v[30:0], q[i]};
      return v;
   endfunction

   function automatic int sum_q(input bit q[$]);
      int s;
      s = 0;
      foreach (q[i]) s += int'(q[i]);
      return s;
   endfunction

   task automatic clear_caps();
      cap_bit.delete();
      cap_done.delete();
      cap_gate.delete();
      cap_cyc.delete();
      cap2.delete();
      det_pos.delete();
      hist   = '0;
      gcount = 0;
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [W-1:0] d);
      bus.in_data  = d;
      bus.in_valid = 1'b1;
      step(1);
      bus.in_valid = 1'b0;
   endtask

   initial begin
      int acc0;
      bus.in_data   = '0;
      bus.in_valid  = 1'b0;
      bus.ser_en    = 1'b1;
      bus2.in_data  = '0;
      bus2.in_valid = 1'b0;
      bus2.ser_en   = 1'b1;

      // Reset state
      #12;
      check("rst_in_ready",  bus.in_ready,  1);
      check("rst_ser_valid", bus.ser_valid, 0);
      check("rst_ser_bit",   bus.ser_bit,   0);
      check("rst_word_done", bus.word_done, 0);
      rst = 1'b0;
      step(2);

      // Single word A5, MSB first
      clear_caps();
      send(8'hA5);
      step(12);
      check("a5_count", cap_bit.size(), 8);
      check("a5_bits",  pack_q(cap_bit), 32'hA5);
      check("a5_done_count", sum_q(cap_done), 1);
      check("a5_done_last",  cap_done[7], 1);
      check("a5_idle_valid", bus.ser_valid, 0);
      check("a5_idle_bit",   bus.ser_bit, 0);

      // Back-to-back A5 then 0F with in_valid held
      clear_caps();
      bus.in_data  = 8'hA5;
      bus.in_valid = 1'b1;
      step(1);
      bus.in_data  = 8'h0F;
      step(7);
      check("b2b_ready_last", bus.in_ready, 1);
      step(1);
      bus.in_valid = 1'b0;
      step(12);
      check("b2b_count", cap_bit.size(), 16);
      check("b2b_bits",  pack_q(cap_bit), 32'hA50F);
      check("b2b_gapless", cap_cyc[15] - cap_cyc[0], 15);
      check("b2b_done_count", sum_q(cap_done), 2);

      // Stall for 3 cycles on bit index 2 of A5
      clear_caps();
      send(8'hA5);
      step(2);
      bus.ser_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("stall_ready", bus.in_ready, 0);
         step(1);
      end
      bus.ser_en = 1'b1;
      step(12);
      check("stall_count", cap_bit.size(), 11);
      check("stall_bits",  pack_q(cap_bit), 32'h5E5);
      check("stall_gated", pack_q(cap_gate), 32'hA5);

      // Asynchronous reset during bit 4
      clear_caps();
      send(8'hA5);
      step(4);
      #2;
      rst = 1'b1;
      #1;
      check("arst_ser_valid", bus.ser_valid, 0);
      check("arst_ser_bit",   bus.ser_bit, 0);
      check("arst_word_done", bus.word_done, 0);
      check("arst_in_ready",  bus.in_ready, 1);
      #10;
      rst = 1'b0;
      step(1);
      clear_caps();
      send(8'hFF);
      step(12);
      check("ff_count", cap_bit.size(), 8);
      check("ff_bits",  pack_q(cap_bit), 32'hFF);
      check("ff_done_count", sum_q(cap_done), 1);

      // LSB-first instance with 01
      clear_caps();
      bus2.in_data  = 8'h01;
      bus2.in_valid = 1'b1;
      step(1);
      bus2.in_valid = 1'b0;
      step(12);
      check("lsb_count", cap2.size(), 8);
      check("lsb_bits",  pack_q(cap2), 32'h80);

      // 101 detector integration with A8
      clear_caps();
      send(8'hA8);
      step(12);
      check("det_gated", pack_q(cap_gate), 32'hA8);
      check("det_pulses", det_pos.size(), 2);
      check("det_pos0", det_pos[0], 3);
      check("det_pos1", det_pos[1], 5);

      // Random traffic against the model
      acc0 = model_accepts;
      for (int i = 0; i < 2000; i++) begin
         bus.in_valid = ($urandom_range(0, 3) != 0);
         bus.in_data  = W'($urandom);
         bus.ser_en   = ($urandom_range(0, 7) != 0);
         step(1);
      end
      bus.in_valid = 1'b0;
      bus.ser_en   = 1'b1;
      step(20);
      check("rand_accepts_min", (model_accepts - acc0) >= 100, 1);
      check("rand_drained", bus.ser_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
